// File: rtl/uart_tx_ctrl_pkg.sv
// Shared UART definitions: FSM state encoding, frame constants and the
// baud divider calculation. Used by the transmitter and the baud generator,
// and intended to be shared with the receive path.
package uart_tx_ctrl_pkg;

    // Transmit FSM states (3-bit encoding shared with the receive path)
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam int unsigned DATA_BITS = 8;
    localparam logic        START_LVL = 1'b0;
    localparam logic        STOP_LVL  = 1'b1;

    // Clocks per bit; integer truncation of CLK_FREQ/BAUD
    function automatic int unsigned calc_div(input int unsigned clk_freq,
                                             input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running baud counter, 0..DIV-1.
//   clk   in  system clock
//   rst_n in  synchronous reset, active-low
//   clear in  restart the count at 0 on the next edge
//   tick  out high during the last clock (count DIV-1) of each bit period
module uart_baud_gen
    import uart_tx_ctrl_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50000000,
    parameter int unsigned BAUD     = 9600
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD);
    localparam int unsigned CW  = (DIV < 2) ? 1 : $clog2(DIV);

    generate
        if (DIV < 2) begin : g_bad_div
            $error("uart_baud_gen: CLK_FREQ/BAUD must be at least 2");
        end
    endgenerate

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            cnt <= '0;
        end else if (cnt == CW'(DIV - 1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == CW'(DIV - 1));

endmodule

// File: rtl/uart_tx_ctrl.sv
// RS232 UART transmitter: start bit, 8 data bits LSB first, optional parity,
// 1 or 2 stop bits. One byte accepted per valid/ready handshake.
//   clk      in      system clock
//   rst_n    in      synchronous reset, active-low
//   tx_data  in  [8] byte to send, sampled on an accepted handshake
//   tx_valid in      tx_data is valid
//   tx_ready out     can accept a byte (IDLE only)
//   rs232_tx out     registered serial line, idles high
//   tx_busy  out     frame in progress
//   tx_done  out     one-cycle pulse as the final stop bit completes
module uart_tx_ctrl
    import uart_tx_ctrl_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       rs232_tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD);

    generate
        if (DIV < 2) begin : g_bad_div
            $error("uart_tx_ctrl: CLK_FREQ/BAUD must be at least 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
            $error("uart_tx_ctrl: STOP_BITS must be 1 or 2");
        end
    endgenerate

    state_t     state;
    logic [7:0] shreg;
    logic [2:0] bit_idx;
    logic       parity_bit;
    logic       tick;
    logic       accept;

    assign accept = tx_valid & tx_ready;

    // Restarting the counter on acceptance gives the start bit a full DIV clks
    uart_baud_gen #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (accept),
        .tick  (tick)
    );

    // bit_idx counts data bits in DATA and stop bits in STOP
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            rs232_tx   <= STOP_LVL;
            tx_ready   <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
            shreg      <= '0;
            bit_idx    <= '0;
            parity_bit <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        shreg      <= tx_data;
                        parity_bit <= (^tx_data) ^ (PARITY_ODD != 0);
                        bit_idx    <= '0;
                        rs232_tx   <= START_LVL;
                        tx_ready   <= 1'b0;
                        tx_busy    <= 1'b1;
                        state      <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        rs232_tx <= shreg[0];
                        shreg    <= shreg >> 1;
                        bit_idx  <= '0;
                        state    <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_idx == 3'(DATA_BITS - 1)) begin
                            bit_idx <= '0;
                            if (PARITY_EN != 0) begin
                                rs232_tx <= parity_bit;
                                state    <= PARITY;
                            end else begin
                                rs232_tx <= STOP_LVL;
                                state    <= STOP;
                            end
                        end else begin
                            rs232_tx <= shreg[0];
                            shreg    <= shreg >> 1;
                            bit_idx  <= bit_idx + 3'd1;
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        rs232_tx <= STOP_LVL;
                        bit_idx  <= '0;
                        state    <= STOP;
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (bit_idx == 3'(STOP_BITS - 1)) begin
                            tx_done  <= 1'b1;
                            tx_ready <= 1'b1;
                            tx_busy  <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                default: begin
                    rs232_tx <= STOP_LVL;
                    tx_ready <= 1'b1;
                    tx_busy  <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
